vga_pic_timing: RTL and testbench

VGA_PIC_TIMING -- requirements
Module: vga_pic_timing

---
 rtl/vga_pic_timing.sv | 140 ++++++++++++++
 tb/tb_vga_pic_timing.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pic_timing.sv
// VGA raster timing with a picture window fetched from a 1-clk-latency memory.
// Two-stage flag pipeline keeps syncs, DE and RGB aligned with the memory read data.
module vga_pic_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int PIC_X    = 220,
    parameter int PIC_Y    = 158,
    parameter int PIC_W    = 200,
    parameter int PIC_H    = 164,
    parameter int RGB_W    = 8,
    parameter logic [RGB_W-1:0] BG_COLOR = '0,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pic_en,
    input  logic [RGB_W-1:0]  pic_data,
    output logic [ADDR_W-1:0] pic_addr,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic [RGB_W-1:0]  rgb,
    output logic              frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int DW      = $clog2(CLK_DIV + 1);

    logic [DW-1:0]     r_div;
    logic [HW-1:0]     r_h_cnt;
    logic [VW-1:0]     r_v_cnt;
    logic [ADDR_W-1:0] r_row_base;
    logic              r_frame_en;

    logic r_s1_tick, r_s1_active, r_s1_hs, r_s1_vs, r_s1_pic, r_s1_origin;
    logic r_s2_tick, r_s2_active, r_s2_hs, r_s2_vs, r_s2_pic, r_s2_origin;

    int                w_h;
    int                w_v;
    int                w_v_nxt;
    logic              w_tick;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_active;
    logic              w_hsync;
    logic              w_vsync;
    logic              w_in_win;
    logic              w_origin;
    logic              w_frame_en_nxt;
    logic [ADDR_W-1:0] w_col;

    assign w_h      = int'(r_h_cnt);
    assign w_v      = int'(r_v_cnt);
    assign w_tick   = (int'(r_div) == CLK_DIV - 1);
    assign w_h_last = (w_h == H_TOTAL - 1);
    assign w_v_last = (w_v == V_TOTAL - 1);
    assign w_v_nxt  = w_v_last ? 0 : w_v + 1;

    assign w_active = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    assign w_hsync  = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
    assign w_vsync  = (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC);
    assign w_in_win = w_active && (w_h >= PIC_X) && (w_h < PIC_X + PIC_W)
                      && (w_v >= PIC_Y) && (w_v < PIC_Y + PIC_H);
    assign w_origin = (w_h == 0) && (w_v == 0);

    // pic_en is only sampled at the frame origin so a frame is never torn
    assign w_frame_en_nxt = (w_tick && w_origin) ? pic_en : r_frame_en;
    // row base accumulates PIC_W per line, so the address needs only an adder
    assign w_col = ADDR_W'(w_h - PIC_X);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div       <= '0;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_row_base  <= '0;
            r_frame_en  <= 1'b0;
            pic_addr    <= '0;
            r_s1_tick   <= 1'b0;
            r_s1_active <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_pic    <= 1'b0;
            r_s1_origin <= 1'b0;
            r_s2_tick   <= 1'b0;
            r_s2_active <= 1'b0;
            r_s2_hs     <= 1'b0;
            r_s2_vs     <= 1'b0;
            r_s2_pic    <= 1'b0;
            r_s2_origin <= 1'b0;
            vga_hs      <= ~HS_POL;
            vga_vs      <= ~VS_POL;
            vga_de      <= 1'b0;
            rgb         <= '0;
            frame_start <= 1'b0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DW'(1);
            if (w_tick) begin
                r_h_cnt <= w_h_last ? '0 : r_h_cnt + HW'(1);
                if (w_h_last) begin
                    r_v_cnt    <= w_v_last ? '0 : r_v_cnt + VW'(1);
                    r_row_base <= (w_v_nxt == PIC_Y) ? '0 : r_row_base + ADDR_W'(PIC_W);
                end
                r_frame_en  <= w_frame_en_nxt;
                r_s1_active <= w_active;
                r_s1_hs     <= w_hsync;
                r_s1_vs     <= w_vsync;
                r_s1_pic    <= w_in_win && w_frame_en_nxt;
                r_s1_origin <= w_origin;
                if (w_in_win) begin
                    pic_addr <= r_row_base + w_col;
                end
            end
            r_s1_tick   <= w_tick;
            r_s2_tick   <= r_s1_tick;
            r_s2_active <= r_s1_active;
            r_s2_hs     <= r_s1_hs;
            r_s2_vs     <= r_s1_vs;
            r_s2_pic    <= r_s1_pic;
            r_s2_origin <= r_s1_origin;
            // pic_data for the stage-2 pixel is valid here, one clk after its address
            vga_hs      <= r_s2_hs ? HS_POL : ~HS_POL;
            vga_vs      <= r_s2_vs ? VS_POL : ~VS_POL;
            vga_de      <= r_s2_active;
            rgb         <= r_s2_pic ? pic_data : (r_s2_active ? BG_COLOR : '0);
            frame_start <= r_s2_tick && r_s2_origin;
        end
    end
endmodule

// File: tb/tb_vga_pic_timing.sv
// Bench for vga_pic_timing: small-raster instances checked every clk against an
// arithmetic position model, a vector table, corner sequences and default-timing measurement.
module tb_vga_pic_timing;
    localparam int NI = 3;
    localparam int CD [NI] = '{1, 3, 1};
    localparam int PX [NI] = '{2, 2, 6};
    localparam int HT = 14;
    localparam int VT = 9;
    localparam int FT = HT * VT;
    localparam logic [7:0] BG = 8'hA5;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic [7:0] rgb;
    } out_t;

    typedef struct {
        int         inst;
        int         h;
        int         v;
        logic [7:0] rgb;
        logic       de;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_s  [NI];
    logic       pen    [NI];
    logic [7:0] pd     [NI];
    logic [7:0] addr_o [NI];
    logic       hs_o   [NI];
    logic       vs_o   [NI];
    logic       de_o   [NI];
    logic       fs_o   [NI];
    logic [7:0] rgb_o  [NI];

    logic        rst_d, pen_d, hs_d, vs_d, de_d, fs_d;
    logic [7:0]  pd_d, rgb_d;
    logic [15:0] addr_d;

    int   errors = 0;
    int   checks = 0;
    int   kc [NI];
    bit   en_fr [NI][64];
    out_t ck_e, ck_a;
    vec_t tbl [$];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            vga_pic_timing #(
                .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
                .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(CD[g]),
                .PIC_X(PX[g]), .PIC_Y(1), .PIC_W(4), .PIC_H(3),
                .RGB_W(8), .BG_COLOR(BG), .ADDR_W(8)
            ) u_dut (
                .clk(clk), .rst(rst_s[g]), .pic_en(pen[g]), .pic_data(pd[g]),
                .pic_addr(addr_o[g]), .vga_hs(hs_o[g]), .vga_vs(vs_o[g]),
                .vga_de(de_o[g]), .rgb(rgb_o[g]), .frame_start(fs_o[g])
            );
        end
    endgenerate

    vga_pic_timing u_def (
        .clk(clk), .rst(rst_d), .pic_en(pen_d), .pic_data(pd_d), .pic_addr(addr_d),
        .vga_hs(hs_d), .vga_vs(vs_d), .vga_de(de_d), .rgb(rgb_d), .frame_start(fs_d)
    );

    // registered-output picture memories: data = low address byte
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) pd[i] <= addr_o[i];
        pd_d <= addr_d[15:8] ^ addr_d[7:0];
    end

    // edges since reset release, and pic_en seen at each frame-origin tick
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst_s[i]) kc[i] <= 0;
            else begin
                kc[i] <= kc[i] + 1;
                if ((kc[i] + 1) % CD[i] == 0 && ((kc[i] + 1) / CD[i] - 1) % FT == 0)
                    en_fr[i][(((kc[i] + 1) / CD[i] - 1) / FT) % 64] <= pen[i];
            end
        end
    end

    // tick j lands on edge CD*(j+1) and is shown two clks later
    function automatic out_t model(input int i, input int k);
        out_t o;
        int   j, p, h, v, f;
        bit   win;
        o = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, rgb: 8'h00};
        if (k < CD[i] + 2) return o;
        j = (k - 2) / CD[i] - 1;
        p = j % FT;
        h = p % HT;
        v = p / HT;
        f = j / FT;
        o.de = (h < 8) && (v < 6);
        o.hs = !(h >= 10 && h < 12);
        o.vs = !(v == 7);
        o.fs = ((k - 2) % CD[i] == 0) && (p == 0);
        win  = o.de && h >= PX[i] && h < PX[i] + 4 && v >= 1 && v < 4;
        if (win && en_fr[i][f % 64]) o.rgb = 8'((v - 1) * 4 + h - PX[i]);
        else if (o.de)               o.rgb = BG;
        else                         o.rgb = 8'h00;
        return o;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                ck_e = model(i, kc[i]);
                ck_a = {hs_o[i], vs_o[i], de_o[i], fs_o[i], rgb_o[i]};
                checks++;
                if (ck_a !== ck_e) begin
                    errors++;
                    $display("FAIL model_inst%0d k=%0d got hs=%b vs=%b de=%b fs=%b rgb=%h required hs=%b vs=%b de=%b fs=%b rgb=%h",
                             i, kc[i], ck_a.hs, ck_a.vs, ck_a.de, ck_a.fs, ck_a.rgb,
                             ck_e.hs, ck_e.vs, ck_e.de, ck_e.fs, ck_e.rgb);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_fs(input int i);
        int n = 0;
        @(negedge clk);
        while (!fs_o[i] && n < 1200) begin
            @(negedge clk);
            n++;
        end
        if (!fs_o[i]) begin
            checks++;
            errors++;
            $display("FAIL frame_start_timeout inst%0d got=0 required=1", i);
        end
    endtask

    task automatic apply_vec(input vec_t t);
        wait_fs(t.inst);
        repeat (CD[t.inst] * (t.v * HT + t.h)) @(negedge clk);
        for (int r = 0; r < CD[t.inst]; r++) begin
            chk($sformatf("vec_rgb_i%0d_h%0d_v%0d_r%0d", t.inst, t.h, t.v, r), rgb_o[t.inst], t.rgb);
            chk($sformatf("vec_de_i%0d_h%0d_v%0d_r%0d", t.inst, t.h, t.v, r), de_o[t.inst], t.de);
            if (r < CD[t.inst] - 1) @(negedge clk);
        end
    endtask

    task automatic measure_line();
        int  n = 0, per = 0, low = 0, deh = 0;
        logic prev;
        prev = hs_d;
        @(negedge clk);
        while (!(prev && !hs_d) && n < 4000) begin
            prev = hs_d;
            @(negedge clk);
            n++;
        end
        if (!(prev && !hs_d)) begin
            chk("hs_fall_timeout", 0, 1);
            return;
        end
        while (per < 4000) begin
            if (!hs_d) low++;
            if (de_d) deh++;
            prev = hs_d;
            @(negedge clk);
            per++;
            if (prev && !hs_d) break;
        end
        chk("def_hs_period", per, 1600);
        chk("def_hs_low", low, 192);
        chk("def_de_per_line", deh, 1280);
        chk("def_vs_idle", vs_d, 1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NI; i++) begin
            rst_s[i] = 1'b1;
            pen[i]   = 1'b1;
        end
        rst_d = 1'b1;
        pen_d = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_def_hs", hs_d, 1);
        chk("rst_def_vs", vs_d, 1);
        chk("rst_def_de", de_d, 0);
        chk("rst_def_rgb", rgb_d, 0);
        chk("rst_def_fs", fs_d, 0);
        chk("rst_def_addr", addr_d, 0);
        for (int i = 0; i < NI; i++) rst_s[i] = 1'b0;
        rst_d = 1'b0;

        tbl.push_back('{0, 0, 1, BG, 1'b1});
        tbl.push_back('{0, 1, 1, BG, 1'b1});
        tbl.push_back('{0, 2, 1, 8'd0, 1'b1});
        tbl.push_back('{0, 3, 1, 8'd1, 1'b1});
        tbl.push_back('{0, 4, 1, 8'd2, 1'b1});
        tbl.push_back('{0, 5, 1, 8'd3, 1'b1});
        tbl.push_back('{0, 6, 1, BG, 1'b1});
        tbl.push_back('{0, 7, 1, BG, 1'b1});
        tbl.push_back('{0, 5, 3, 8'd11, 1'b1});
        tbl.push_back('{0, 3, 0, BG, 1'b1});
        tbl.push_back('{0, 9, 1, 8'd0, 1'b0});
        tbl.push_back('{0, 2, 6, 8'd0, 1'b0});
        tbl.push_back('{1, 2, 1, 8'd0, 1'b1});
        tbl.push_back('{1, 5, 1, 8'd3, 1'b1});
        tbl.push_back('{1, 5, 3, 8'd11, 1'b1});
        tbl.push_back('{2, 6, 1, 8'd0, 1'b1});
        tbl.push_back('{2, 7, 1, 8'd1, 1'b1});
        tbl.push_back('{2, 6, 2, 8'd4, 1'b1});
        tbl.push_back('{2, 7, 2, 8'd5, 1'b1});
        tbl.push_back('{2, 7, 3, 8'd9, 1'b1});
        tbl.push_back('{2, 8, 1, 8'd0, 1'b0});
        foreach (tbl[t]) apply_vec(tbl[t]);

        // pic_en drops mid-window: current frame keeps the picture, next shows BG
        wait_fs(0);
        repeat (2 * HT + 3) @(negedge clk);
        chk("en_drop_cur_px", rgb_o[0], 5);
        pen[0] = 1'b0;
        repeat (HT + 2) @(negedge clk);
        chk("en_drop_cur_last", rgb_o[0], 11);
        wait_fs(0);
        repeat (2 * HT + 3) @(negedge clk);
        chk("en_drop_next_bg", rgb_o[0], BG);
        pen[0] = 1'b1;

        // one-clk reset mid-line on the divided instance
        wait_fs(1);
        repeat (3 * (HT + 4)) @(negedge clk);
        rst_s[1] = 1'b1;
        @(negedge clk);
        rst_s[1] = 1'b0;
        chk("midrst_hs", hs_o[1], 1);
        chk("midrst_vs", vs_o[1], 1);
        chk("midrst_de", de_o[1], 0);
        chk("midrst_rgb", rgb_o[1], 0);
        chk("midrst_fs", fs_o[1], 0);
        chk("midrst_addr", addr_o[1], 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs_o[1] && n < 2000);
        chk("midrst_fs_delay", n, 5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs_o[1] && n < 2000);
        chk("frame_period_cd3", n, 3 * FT);

        // random pic_en toggles and reset pulses, judged by the model each clk
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 199) == 0) pen[i] = ~pen[i];
                if (rst_s[i]) rst_s[i] = 1'b0;
                else if ($urandom_range(0, 999) == 0) rst_s[i] = 1'b1;
            end
        end
        for (int i = 0; i < NI; i++) rst_s[i] = 1'b0;

        for (int l = 0; l < 3; l++) measure_line();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
